// File: rtl/sumn_seq.sv
// Multi-cycle adder: adds CHUNK bits per clock through a ripple chain of full-adder cells.
// Define SUMN_SUB_EN to let sub=1 compute A - B; otherwise sub is ignored.

module sumn_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module sumn_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             c_in,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             c_out,
    output logic             ovf
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NCH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_r, b_r;
    logic [KW-1:0]    k;
    logic             carry;
    logic             capture, step;
    logic [CHUNK-1:0] a_c, b_c, sum_c;
    logic [CHUNK:0]   cy;

`ifndef SUMN_SUB_EN
    logic unused_sub;
    assign unused_sub = sub;
`endif

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        capture   = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    capture   = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (k == K_LAST) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    capture   = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand chunk select for the current step
    always_comb begin
        a_c = '0;
        b_c = '0;
        for (int i = 0; i < NCH; i++) begin
            if (k == KW'(i)) begin
                a_c = a_r[i*CHUNK +: CHUNK];
                b_c = b_r[i*CHUNK +: CHUNK];
            end
        end
    end

    assign cy[0] = carry;

    for (genvar g = 0; g < CHUNK; g++) begin : g_fa
        sumn_fa u_fa (
            .a  (a_c[g]),
            .b  (b_c[g]),
            .ci (cy[g]),
            .s  (sum_c[g]),
            .co (cy[g+1])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            k     <= '0;
            carry <= 1'b0;
            S     <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                a_r <= A;
                k   <= '0;
`ifdef SUMN_SUB_EN
                // Subtract as A + ~B + 1; the caller's carry-in is not used.
                b_r   <= sub ? ~B : B;
                carry <= sub ? 1'b1 : c_in;
`else
                b_r   <= B;
                carry <= c_in;
`endif
            end else if (step) begin
                for (int i = 0; i < NCH; i++) begin
                    if (k == KW'(i)) S[i*CHUNK +: CHUNK] <= sum_c;
                end
                carry <= cy[CHUNK];
                if (k == K_LAST) begin
                    k     <= '0;
                    c_out <= cy[CHUNK];
                    ovf   <= cy[CHUNK] ^ cy[CHUNK-1];
                end else begin
                    k <= k + KW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_sumn_seq.sv
// Directed bench for sumn_seq: 4-chunk instance plus a single-chunk instance on shared inputs.

module tb_sumn_seq;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] A, B;
    logic        c_in, sub;
    logic        busy, done, c_out, ovf;
    logic [15:0] S;
    logic        busy1, done1, c_out1, ovf1;
    logic [15:0] S1;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sumn_seq #(.WIDTH(16), .CHUNK(4)) u_dut (
        .clk(clk), .reset(reset), .start(start), .A(A), .B(B), .c_in(c_in), .sub(sub),
        .busy(busy), .done(done), .S(S), .c_out(c_out), .ovf(ovf)
    );

    sumn_seq #(.WIDTH(16), .CHUNK(16)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .A(A), .B(B), .c_in(c_in), .sub(sub),
        .busy(busy1), .done(done1), .S(S1), .c_out(c_out1), .ovf(ovf1)
    );

    typedef struct {
        logic [15:0] a, b;
        logic        cin, sb;
        logic [15:0] s;
        logic        co, ov;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input vec_t v, input string nm);
        int n;
        A = v.a; B = v.b; c_in = v.cin; sub = v.sb; start = 1'b1;
        tick();
        start = 1'b0;
        chk({nm, " busy"}, 32'(busy), 32'd1);
        tick();
        chk({nm, " done1"}, 32'(done1), 32'd1);
        chk({nm, " S1"}, 32'(S1), 32'(v.s));
        chk({nm, " cout1"}, 32'(c_out1), 32'(v.co));
        chk({nm, " ovf1"}, 32'(ovf1), 32'(v.ov));
        n = 1;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        chk({nm, " latency"}, 32'(n), 32'd4);
        chk({nm, " S"}, 32'(S), 32'(v.s));
        chk({nm, " cout"}, 32'(c_out), 32'(v.co));
        chk({nm, " ovf"}, 32'(ovf), 32'(v.ov));
        chk({nm, " busy_end"}, 32'(busy), 32'd0);
        tick();
        chk({nm, " done_pulse"}, 32'(done), 32'd0);
        chk({nm, " S_hold"}, 32'(S), 32'(v.s));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
`ifdef SUMN_SUB_EN
        vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
`else
        vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'h000C, 1'b0, 1'b0};
`endif
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[5] = '{16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[7] = '{16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[8] = '{16'h00F0, 16'h0F10, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};

        reset = 1'b1; start = 1'b0; A = '0; B = '0; c_in = 1'b0; sub = 1'b0;
        tick();
        tick();
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst S", 32'(S), 32'd0);
        chk("rst cout", 32'(c_out), 32'd0);
        chk("rst ovf", 32'(ovf), 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) run_op(vecs[i], $sformatf("vec%0d", i));

        // Start re-pulsed with new operands mid-run must be ignored
        begin
            int n;
            A = 16'h1234; B = 16'h4321; c_in = 1'b0; sub = 1'b0; start = 1'b1;
            tick();
            A = 16'hFFFF; B = 16'hFFFF; c_in = 1'b1;
            tick();
            tick();
            start = 1'b0;
            n = 2;
            while (!done && n < 20) begin
                tick();
                n++;
            end
            chk("repulse latency", 32'(n), 32'd4);
            chk("repulse S", 32'(S), 32'h5555);
            chk("repulse cout", 32'(c_out), 32'd0);
            tick();
            tick();
        end

        // Reset in the second RUN cycle
        A = 16'h1111; B = 16'h1111; c_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("midrst busy_pre", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst done", 32'(done), 32'd0);
        chk("midrst S", 32'(S), 32'd0);
        chk("midrst cout", 32'(c_out), 32'd0);
        chk("midrst ovf", 32'(ovf), 32'd0);
        #1 reset = 1'b0;
        tick();
        chk("midrst idle", 32'({busy, done}), 32'd0);
        v = '{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};
        run_op(v, "postrst");

        // Start held high: results every NCH+1 cycles
        A = 16'h0001; B = 16'h0002; c_in = 1'b0; sub = 1'b0; start = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk($sformatf("held done c%0d", i), 32'(done), 32'((i % 5) == 0));
            chk($sformatf("held done1 c%0d", i), 32'(done1), 32'((i % 2) == 0));
            if ((i % 5) == 0) chk($sformatf("held S c%0d", i), 32'(S), 32'h0003);
        end
        start = 1'b0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
